// File: rtl/fwd_stall_ctrl_pkg.sv
// Shared encodings and reset values for the forwarding/stall controller.
// Forward-select codes, exception FSM encoding and counter reset values.
package fwd_stall_ctrl_pkg;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_D_E    = 2'b01;
    localparam logic [1:0] FWD_D_MALU = 2'b10;
    localparam logic [1:0] FWD_D_MLD  = 2'b11;
    localparam logic [1:0] FWD_E_W    = 2'b01;
    localparam logic [1:0] FWD_E_M    = 2'b10;

    localparam logic [0:0] EXC_IDLE  = 1'b0;
    localparam logic [0:0] EXC_FLUSH = 1'b1;

    localparam logic [7:0] MD_CNT_RST   = 8'd0;
    localparam logic [2:0] HOLD_CNT_RST = 3'd0;

endpackage

// File: rtl/fwd_stall_ctrl_fwd_sel.sv
// Per-operand forward selector: a nearer producer A beats a farther producer B.
// B may report an alternate code (e.g. load result) when altB is set.
module fwd_sel
    import fwd_stall_ctrl_pkg::*;
#(
    parameter int         RAW        = 5,
    parameter logic [1:0] CODE_A     = FWD_D_E,
    parameter logic [1:0] CODE_B     = FWD_D_MALU,
    parameter logic [1:0] CODE_B_ALT = FWD_D_MLD
) (
    input  logic [RAW-1:0] src,
    input  logic           en,
    input  logic           wrA,
    input  logic [RAW-1:0] dstA,
    input  logic           blkA,
    input  logic           wrB,
    input  logic [RAW-1:0] dstB,
    input  logic           altB,
    output logic [1:0]     sel
);

    always_comb begin
        sel = FWD_RF;
        if (en && (src != '0)) begin
            if (wrA && !blkA && (dstA == src)) begin
                sel = CODE_A;
            end else if ((dstB == src) && (wrB || altB)) begin
                // a load in M is forwarded from the load path even without wr
                sel = altB ? CODE_B_ALT : CODE_B;
            end
        end
    end

endmodule

// File: rtl/fwd_stall_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use and mul/div stalls,
// and exception flush sequencing. Flush always dominates stalls.
module fwd_stall_ctrl
    import fwd_stall_ctrl_pkg::*;
#(
    parameter int NSRC     = 2,
    parameter int RAW      = 5,
    parameter int MD_LAT   = 32,
    parameter int EXC_HOLD = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NSRC*RAW-1:0] src_d,
    input  logic [NSRC-1:0]     use_d,
    input  logic [NSRC*RAW-1:0] src_e,
    input  logic                wr_e,
    input  logic                wr_m,
    input  logic                wr_w,
    input  logic [RAW-1:0]      dst_e,
    input  logic [RAW-1:0]      dst_m,
    input  logic [RAW-1:0]      dst_w,
    input  logic                ld_e,
    input  logic                ld_m,
    input  logic                md_start_e,
    input  logic                exc_m,
    output logic [NSRC*2-1:0]   fwd_d,
    output logic [NSRC*2-1:0]   fwd_e,
    output logic                stall_f,
    output logic                stall_d,
    output logic                stall_e,
    output logic                flush_f,
    output logic                flush_d,
    output logic                flush_e,
    output logic                flush_m,
    output logic                md_busy
);

    localparam logic [7:0] MD_LOAD   = 8'(MD_LAT - 1);
    localparam logic [2:0] HOLD_LOAD = 3'(EXC_HOLD - 1);

    logic [0:0]      excState;
    logic [2:0]      holdCnt;
    logic [7:0]      mdCnt;
    logic [NSRC-1:0] luHit;
    logic            mdBusy;
    logic            flushReq;
    logic            flushAct;
    logic            mdStall;
    logic            luStall;

    for (genvar gi = 0; gi < NSRC; gi++) begin : gOp
        fwd_sel #(
            .RAW        (RAW),
            .CODE_A     (FWD_D_E),
            .CODE_B     (FWD_D_MALU),
            .CODE_B_ALT (FWD_D_MLD)
        ) uFwdD (
            .src  (src_d[gi*RAW +: RAW]),
            .en   (use_d[gi]),
            .wrA  (wr_e),
            .dstA (dst_e),
            .blkA (ld_e),
            .wrB  (wr_m),
            .dstB (dst_m),
            .altB (ld_m),
            .sel  (fwd_d[gi*2 +: 2])
        );

        fwd_sel #(
            .RAW        (RAW),
            .CODE_A     (FWD_E_M),
            .CODE_B     (FWD_E_W),
            .CODE_B_ALT (FWD_E_W)
        ) uFwdE (
            .src  (src_e[gi*RAW +: RAW]),
            .en   (1'b1),
            .wrA  (wr_m),
            .dstA (dst_m),
            .blkA (1'b0),
            .wrB  (wr_w),
            .dstB (dst_w),
            .altB (1'b0),
            .sel  (fwd_e[gi*2 +: 2])
        );

        // load-use applies whether or not the operand is consumed in D
        assign luHit[gi] = ld_e && (src_d[gi*RAW +: RAW] != '0)
                           && (src_d[gi*RAW +: RAW] == dst_e);
    end

    assign mdBusy   = (mdCnt != '0);
    assign flushReq = exc_m || (excState == EXC_FLUSH);
    assign flushAct = resetn && flushReq;
    assign mdStall  = resetn && (mdBusy || md_start_e);
    assign luStall  = resetn && (|luHit);

    assign stall_f = !flushAct && (luStall || mdStall);
    assign stall_d = !flushAct && (luStall || mdStall);
    assign stall_e = !flushAct && mdStall;
    // no bubble into E while E itself is held by mul/div
    assign flush_e = flushAct || (luStall && !mdStall);
    assign flush_f = flushAct;
    assign flush_d = flushAct;
    assign flush_m = flushAct;
    assign md_busy = mdBusy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            excState <= EXC_IDLE;
            holdCnt  <= HOLD_CNT_RST;
            mdCnt    <= MD_CNT_RST;
        end else begin
            case (excState)
                EXC_IDLE: begin
                    if (exc_m) begin
                        excState <= EXC_FLUSH;
                        holdCnt  <= HOLD_LOAD;
                    end
                end
                EXC_FLUSH: begin
                    if (holdCnt == 3'd0) begin
                        excState <= EXC_IDLE;
                    end else begin
                        holdCnt <= holdCnt - 3'd1;
                    end
                end
                default: excState <= EXC_IDLE;
            endcase

            if (flushReq) begin
                mdCnt <= MD_CNT_RST;
            end else if (mdBusy) begin
                mdCnt <= mdCnt - 8'd1;
            end else if (md_start_e) begin
                mdCnt <= MD_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Scoreboard bench for fwd_stall_ctrl (NSRC=3, RAW=6, MD_LAT=32, EXC_HOLD=3):
// the driver predicts each cycle into a queue, the monitor pops and compares.
module tb_fwd_stall_ctrl;

    localparam int NSRC     = 3;
    localparam int RAW      = 6;
    localparam int MD_LAT   = 32;
    localparam int EXC_HOLD = 3;

    logic                clk = 1'b0;
    logic                resetn;
    logic [NSRC*RAW-1:0] src_d, src_e;
    logic [NSRC-1:0]     use_d;
    logic                wr_e, wr_m, wr_w;
    logic [RAW-1:0]      dst_e, dst_m, dst_w;
    logic                ld_e, ld_m, md_start_e, exc_m;
    logic [NSRC*2-1:0]   fwd_d, fwd_e;
    logic                stall_f, stall_d, stall_e;
    logic                flush_f, flush_d, flush_e, flush_m, md_busy;

    typedef struct packed {
        logic [NSRC*2-1:0] fd;
        logic [NSRC*2-1:0] fe;
        logic [2:0]        st;
        logic [3:0]        fl;
        logic              busy;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   mdRemain = 0;
    int   flushLeft = 0;

    fwd_stall_ctrl #(.NSRC(NSRC), .RAW(RAW), .MD_LAT(MD_LAT), .EXC_HOLD(EXC_HOLD)) dut (
        .clk(clk), .resetn(resetn), .src_d(src_d), .use_d(use_d), .src_e(src_e),
        .wr_e(wr_e), .wr_m(wr_m), .wr_w(wr_w), .dst_e(dst_e), .dst_m(dst_m), .dst_w(dst_w),
        .ld_e(ld_e), .ld_m(ld_m), .md_start_e(md_start_e), .exc_m(exc_m),
        .fwd_d(fwd_d), .fwd_e(fwd_e), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_f(flush_f), .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] refFwdD(int i);
        logic [RAW-1:0] s;
        s = src_d[i*RAW +: RAW];
        if (!use_d[i] || s == 0) return 2'b00;
        if (wr_e && !ld_e && dst_e == s) return 2'b01;
        if (ld_m && dst_m == s) return 2'b11;
        if (wr_m && dst_m == s) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [1:0] refFwdE(int i);
        logic [RAW-1:0] s;
        s = src_e[i*RAW +: RAW];
        if (s == 0) return 2'b00;
        if (wr_m && dst_m == s) return 2'b10;
        if (wr_w && dst_w == s) return 2'b01;
        return 2'b00;
    endfunction

    // expected outputs for the current inputs, then advance the model one clock
    task automatic predict();
        exp_t e;
        bit   fl, md, lu;
        for (int i = 0; i < NSRC; i++) begin
            e.fd[i*2 +: 2] = refFwdD(i);
            e.fe[i*2 +: 2] = refFwdE(i);
        end
        if (!resetn) begin
            e.st = 3'b000;
            e.fl = 4'b0000;
            e.busy = 1'b0;
            mdRemain = 0;
            flushLeft = 0;
        end else begin
            fl = exc_m || (flushLeft > 0);
            md = (mdRemain > 0) || md_start_e;
            lu = 1'b0;
            for (int i = 0; i < NSRC; i++)
                if (ld_e && src_d[i*RAW +: RAW] != 0 && src_d[i*RAW +: RAW] == dst_e) lu = 1'b1;
            e.busy = (mdRemain > 0);
            e.st = fl ? 3'b000 : {lu || md, lu || md, md};
            e.fl = {fl, fl, fl || (lu && !md), fl};
            if (flushLeft > 0) flushLeft--;
            else if (exc_m) flushLeft = EXC_HOLD;
            if (fl) mdRemain = 0;
            else if (mdRemain > 0) mdRemain--;
            else if (md_start_e) mdRemain = MD_LAT - 1;
        end
        q.push_back(e);
    endtask

    task automatic nxt();
        @(negedge clk);
        src_d = '0; src_e = '0; use_d = '0;
        wr_e = 0; wr_m = 0; wr_w = 0; dst_e = '0; dst_m = '0; dst_w = '0;
        ld_e = 0; ld_m = 0; md_start_e = 0; exc_m = 0;
    endtask

    function automatic logic [RAW-1:0] pickA();
        case ($urandom_range(0, 4))
            0: return 6'd0;
            1: return 6'd1;
            2: return 6'd2;
            3: return 6'd3;
            default: return 6'd63;
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("fwd_d", 32'(fwd_d), 32'(e.fd));
                chk("fwd_e", 32'(fwd_e), 32'(e.fe));
                chk("stall", 32'({stall_f, stall_d, stall_e}), 32'(e.st));
                chk("flush", 32'({flush_f, flush_d, flush_e, flush_m}), 32'(e.fl));
                chk("md_busy", 32'(md_busy), 32'(e.busy));
            end
        end
    end

    initial begin : driver
        int busyN, stallN, flN, stN, guard;
        resetn = 1'b0;
        nxt(); predict();
        nxt(); resetn = 1'b1; predict();

        nxt(); src_e[5:0] = 6'd3; wr_m = 1; dst_m = 6'd3; wr_w = 1; dst_w = 6'd3; predict();
        #3 chk("fwd_e_m_priority", 32'(fwd_e[1:0]), 32'h2);
        nxt(); wr_m = 1; wr_w = 1; predict();
        #3 chk("fwd_e_src0", 32'(fwd_e[1:0]), 32'h0);

        nxt(); ld_e = 1; wr_e = 1; dst_e = 6'd8; src_d[11:6] = 6'd8; predict();
        #3 chk("lu_stall", 32'({stall_f, stall_d, flush_e, stall_e}), 32'hE);
        nxt(); ld_m = 1; wr_m = 1; dst_m = 6'd8; src_d[11:6] = 6'd8; use_d[1] = 1; predict();
        #3 chk("lu_fwd_load", 32'(fwd_d[3:2]), 32'h3);
        chk("lu_one_cycle", 32'({stall_f, stall_d, flush_e}), 32'h0);

        nxt(); wr_e = 1; dst_e = 6'd63; src_d[17:12] = 6'd63; use_d[2] = 1; predict();
        #3 chk("op2_fwd_e", 32'(fwd_d[5:4]), 32'h1);

        busyN = 0; stallN = 0;
        for (int k = 0; k < 40; k++) begin
            nxt();
            if (k == 0 || k == 10) md_start_e = 1;
            if (k == 5) begin ld_e = 1; wr_e = 1; dst_e = 6'd4; src_d[5:0] = 6'd4; end
            predict();
            #3;
            busyN += int'(md_busy);
            stallN += int'(stall_f & stall_d & stall_e);
        end
        chk("md_busy_cycles", 32'(busyN), 32'd31);
        chk("md_stall_cycles", 32'(stallN), 32'd32);

        nxt(); md_start_e = 1; predict();
        guard = 0;
        while (mdRemain != 10 && guard < 40) begin nxt(); predict(); guard++; end
        chk("md_reach_10", 32'(guard), 32'd21);
        nxt(); exc_m = 1; predict();
        #3 chk("exc_flush_now", 32'({flush_f, flush_d, flush_e, flush_m}), 32'hF);
        stN = int'(stall_f | stall_d | stall_e);
        flN = 0;
        for (int j = 0; j < 6; j++) begin
            nxt();
            if (j == 0) begin ld_e = 1; dst_e = 6'd2; src_d[5:0] = 6'd2; end
            if (j == 1) exc_m = 1;
            predict();
            #3;
            if (j == 0) chk("md_cleared", 32'(md_busy), 32'd0);
            flN += int'(flush_m);
            stN += int'(stall_f | stall_d | stall_e);
        end
        chk("exc_hold_cycles", 32'(flN), 32'd3);
        chk("exc_no_stall", 32'(stN), 32'd0);

        nxt(); md_start_e = 1; predict();
        for (int j = 0; j < 3; j++) begin nxt(); predict(); end
        nxt(); resetn = 1'b0; predict();
        #3 chk("rst_mid_md", 32'({stall_f, stall_d, stall_e, flush_f, flush_d, flush_e, flush_m, md_busy}), 32'h0);
        nxt(); resetn = 1'b1; predict();
        #3 chk("rst_md_released", 32'({stall_f, stall_d, stall_e, md_busy}), 32'h0);
        nxt(); exc_m = 1; predict();
        nxt(); predict();
        nxt(); resetn = 1'b0; predict();
        #3 chk("rst_mid_flush", 32'({stall_f, stall_d, stall_e, flush_f, flush_d, flush_e, flush_m}), 32'h0);
        nxt(); resetn = 1'b1; predict();
        #3 chk("rst_flush_released", 32'({flush_f, flush_d, flush_e, flush_m}), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            nxt();
            for (int i = 0; i < NSRC; i++) begin
                src_d[i*RAW +: RAW] = pickA();
                src_e[i*RAW +: RAW] = pickA();
            end
            use_d = 3'($urandom_range(0, 7));
            wr_e = 1'($urandom_range(0, 1)); wr_m = 1'($urandom_range(0, 1)); wr_w = 1'($urandom_range(0, 1));
            ld_e = 1'($urandom_range(0, 1)); ld_m = 1'($urandom_range(0, 1));
            dst_e = pickA(); dst_m = pickA(); dst_w = pickA();
            md_start_e = ($urandom_range(0, 29) == 0);
            exc_m = ($urandom_range(0, 39) == 0);
            resetn = ($urandom_range(0, 199) != 0);
            predict();
        end

        nxt(); resetn = 1'b1; predict();
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
